// File: rtl/icfh_4_stream_pkg.sv
// Shared constants for the inverse 4-point CFH stream: sample width, frame length
// and the FSM state encodings.
package icfh_4_stream_pkg;

    localparam int unsigned CFH_W   = 12;
    localparam int unsigned CFH_NPT = 4;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    // Index of the final sample in a frame, for both the input and output counters.
    localparam logic [1:0] LAST_IDX = 2'(CFH_NPT - 1);

endpackage

// File: rtl/icfh_4_core.sv
// Combinational inverse CFH butterfly: n0=(X0+X2)/2, n1=(X1+X3)/2, n2=(X0-X2)/2,
// n3=(X1-X3)/2, computed at W+1 bits and floored.
module icfh_4_core
    import icfh_4_stream_pkg::*;
#(
    parameter int unsigned W = CFH_W
) (
    input  logic [W-1:0] i_x0,
    input  logic [W-1:0] i_x1,
    input  logic [W-1:0] i_x2,
    input  logic [W-1:0] i_x3,
    output logic [W-1:0] o_n0,
    output logic [W-1:0] o_n1,
    output logic [W-1:0] o_n2,
    output logic [W-1:0] o_n3
);

    logic [W:0] w_sum02;
    logic [W:0] w_sum13;
    logic [W:0] w_dif02;
    logic [W:0] w_dif13;
    logic       w_unused;

    assign w_sum02 = {i_x0[W-1], i_x0} + {i_x2[W-1], i_x2};
    assign w_sum13 = {i_x1[W-1], i_x1} + {i_x3[W-1], i_x3};
    assign w_dif02 = {i_x0[W-1], i_x0} - {i_x2[W-1], i_x2};
    assign w_dif13 = {i_x1[W-1], i_x1} - {i_x3[W-1], i_x3};

    // Keeping bits W:1 is an arithmetic shift right by one (floor); the halved value
    // always fits in W bits, so bit 0 is the only one discarded.
    assign o_n0 = w_sum02[W:1];
    assign o_n1 = w_sum13[W:1];
    assign o_n2 = w_dif02[W:1];
    assign o_n3 = w_dif13[W:1];

    assign w_unused = ^{w_sum02[0], w_sum13[0], w_dif02[0], w_dif13[0]};

endmodule

// File: rtl/icfh_4_stream.sv
// Streaming inverse 4-point CFH: collects X0..X3, reconstructs n0..n3 in one compute
// cycle and emits them serially with backpressure.
module icfh_4_stream
    import icfh_4_stream_pkg::*;
#(
    parameter int unsigned W = CFH_W
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         s_valid,
    input  logic         s_first,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic         m_last,
    input  logic         m_ready,
    output logic         frame_err
);

    logic [1:0]   r_state;
    logic [1:0]   r_in_cnt;
    logic [1:0]   r_out_cnt;
    logic         r_frame_err;
    logic [W-1:0] r_x [CFH_NPT];
    logic [W-1:0] r_n [CFH_NPT];

    logic         w_in_xfer;
    logic         w_out_xfer;
    logic [W-1:0] w_n0;
    logic [W-1:0] w_n1;
    logic [W-1:0] w_n2;
    logic [W-1:0] w_n3;

    assign s_ready    = (r_state == ST_COLLECT);
    assign m_valid    = (r_state == ST_EMIT);
    assign m_last     = m_valid && (r_out_cnt == LAST_IDX);
    assign m_data     = m_valid ? r_n[r_out_cnt] : '0;
    assign frame_err  = r_frame_err;
    assign w_in_xfer  = s_valid && s_ready;
    assign w_out_xfer = m_valid && m_ready;

    icfh_4_core #(
        .W (W)
    ) u_core (
        .i_x0 (r_x[0]),
        .i_x1 (r_x[1]),
        .i_x2 (r_x[2]),
        .i_x3 (r_x[3]),
        .o_n0 (w_n0),
        .o_n1 (w_n1),
        .o_n2 (w_n2),
        .o_n3 (w_n3)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_COLLECT;
            r_in_cnt    <= 2'd0;
            r_out_cnt   <= 2'd0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < CFH_NPT; i++) begin
                r_x[i] <= '0;
                r_n[i] <= '0;
            end
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (w_in_xfer) begin
                        // A frame start mid-frame drops the partial frame and restarts on it.
                        if (s_first && (r_in_cnt != 2'd0)) begin
                            r_x[0]      <= s_data;
                            r_in_cnt    <= 2'd1;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_x[r_in_cnt] <= s_data;
                            r_in_cnt      <= r_in_cnt + 2'd1;
                            if (r_in_cnt == LAST_IDX) begin
                                r_state <= ST_COMPUTE;
                            end
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_n[0]  <= w_n0;
                    r_n[1]  <= w_n1;
                    r_n[2]  <= w_n2;
                    r_n[3]  <= w_n3;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (w_out_xfer) begin
                        r_out_cnt <= r_out_cnt + 2'd1;
                        if (r_out_cnt == LAST_IDX) begin
                            r_state <= ST_COLLECT;
                        end
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_icfh_4_stream.sv
// Bench for icfh_4_stream: frame-level reference model checked every cycle, plus
// directed frames with hand-computed results.
module tb_icfh_4_stream;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_first = 1'b0;
    logic [11:0] s_data = 12'd0;
    logic        s_ready;
    logic        m_valid;
    logic [11:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    logic bp_ready = 1'b1;

    // Reference model state
    logic [11:0] expq[$];
    int          part[$];
    int          delay = 0;
    bit          err_next = 1'b0;
    int          err_cnt = 0;
    logic [11:0] outlog[$];
    bit          exp_ready;
    bit          exp_mvalid;
    int          a0, a1, a2, a3;

    icfh_4_stream dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .s_valid   (s_valid),
        .s_first   (s_first),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting, expected DUT progress at %0t", name, $time);
    endtask

    // Frame-level model: an output frame exists from the cycle after the 4th input
    // and is presented two cycles after it; s_ready only while nothing is pending.
    always @(negedge CLK) begin
        if (RESET) begin
            expq.delete();
            part.delete();
            delay = 0;
            err_next = 1'b0;
        end else begin
            exp_ready  = (expq.size() == 0);
            exp_mvalid = (expq.size() != 0) && (delay == 0);
            chk("s_ready", s_ready, exp_ready);
            chk("m_valid", m_valid, exp_mvalid);
            chk("frame_err", frame_err, err_next);
            if (frame_err) err_cnt++;
            if (exp_mvalid) begin
                chk("m_data", $signed(m_data), $signed(expq[0]));
                chk("m_last", m_last, (expq.size() == 1));
                if (m_ready) begin
                    outlog.push_back(m_data);
                    void'(expq.pop_front());
                end
            end else begin
                chk("m_last_idle", m_last, 0);
            end
            err_next = 1'b0;
            if (delay > 0) delay--;
            if (s_valid && exp_ready) begin
                if (s_first && part.size() != 0) begin
                    part.delete();
                    err_next = 1'b1;
                end
                part.push_back($signed(s_data));
                if (part.size() == 4) begin
                    a0 = part[0]; a1 = part[1]; a2 = part[2]; a3 = part[3];
                    expq.push_back(12'((a0 + a2) >>> 1));
                    expq.push_back(12'((a1 + a3) >>> 1));
                    expq.push_back(12'((a0 - a2) >>> 1));
                    expq.push_back(12'((a1 - a3) >>> 1));
                    part.delete();
                    delay = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rdy_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 2) m_ready = bp_ready;
            else m_ready = 1'b1;
        end
    end

    task automatic put(input logic [11:0] d, input logic f);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_first = f;
        @(negedge CLK);
        while (!s_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!s_ready) fail_timeout("put");
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic put_frame(input int x0, input int x1, input int x2, input int x3);
        put(12'(x0), 1'b1);
        put(12'(x1), 1'b0);
        put(12'(x2), 1'b0);
        put(12'(x3), 1'b0);
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (outlog.size() < n && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (outlog.size() < n) fail_timeout("wait_out");
        @(posedge CLK);
        #1;
    endtask

    task automatic check_log(input string name, input int e0, input int e1, input int e2,
                             input int e3);
        chk({name, "_count"}, outlog.size(), 4);
        chk({name, "_n0"}, $signed(outlog[0]), e0);
        chk({name, "_n1"}, $signed(outlog[1]), e1);
        chk({name, "_n2"}, $signed(outlog[2]), e2);
        chk({name, "_n3"}, $signed(outlog[3]), e3);
    endtask

    initial begin
        int k;
        int e0;
        #2;
        chk("reset_s_ready", s_ready, 1);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_frame_err", frame_err, 0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Basic frame with latency check
        outlog.delete();
        put_frame(10, 4, 6, 2);
        @(negedge CLK);
        chk("lat_t1_m_valid", m_valid, 0);
        @(negedge CLK);
        chk("lat_t2_m_valid", m_valid, 1);
        chk("lat_t2_m_data", m_data, 8);
        wait_out(4);
        check_log("basic", 8, 3, 2, 1);

        // Floor rounding
        outlog.delete();
        put_frame(-5, 0, 2, 0);
        wait_out(4);
        check_log("floor", -2, 0, -4, 0);

        // Extremes and round trip of (100,-7,33,5) through the forward stage
        outlog.delete();
        put_frame(2047, -2048, 2047, -2048);
        wait_out(4);
        check_log("extreme", 2047, -2048, 0, 0);
        outlog.delete();
        put_frame(133, -2, 67, -12);
        wait_out(4);
        check_log("roundtrip", 100, -7, 33, 5);

        // Backpressure while n1 is presented
        rdy_mode = 2;
        bp_ready = 1'b1;
        outlog.delete();
        put_frame(10, 4, 6, 2);
        k = 0;
        @(negedge CLK);
        while (!m_valid && k < 20) begin
            @(negedge CLK);
            k++;
        end
        if (!m_valid) fail_timeout("bp_n0");
        bp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, 3);
        end
        bp_ready = 1'b1;
        wait_out(4);
        check_log("bp", 8, 3, 2, 1);
        rdy_mode = 0;

        // Resync on an early s_first
        outlog.delete();
        e0 = err_cnt;
        put(12'd10, 1'b1);
        put(12'd4, 1'b0);
        put(12'd7, 1'b1);
        put(12'd1, 1'b0);
        put(12'd3, 1'b0);
        put(12'd1, 1'b0);
        wait_out(4);
        check_log("resync", 5, 1, 2, 0);
        chk("resync_pulses", err_cnt - e0, 1);

        // Asynchronous reset mid-EMIT after n1
        outlog.delete();
        put_frame(10, 4, 6, 2);
        k = 0;
        while (outlog.size() < 2 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (outlog.size() < 2) fail_timeout("rst_wait_n1");
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_m_data", m_data, 0);
        chk("async_s_ready", s_ready, 1);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        outlog.delete();
        put_frame(10, 4, 6, 2);
        wait_out(4);
        check_log("post_reset", 8, 3, 2, 1);

        // Randomized frames, random resyncs, gaps and backpressure
        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) put(12'($urandom_range(0, 4095)), (j == 0));
            end
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge CLK);
                    #1;
                end
                if (j == 0) put(12'($urandom_range(0, 4095)), ($urandom_range(0, 3) != 0));
                else put(12'($urandom_range(0, 4095)), ($urandom_range(0, 15) == 0));
            end
        end
        k = 0;
        while (expq.size() != 0 && k < 500) begin
            @(negedge CLK);
            k++;
        end
        if (expq.size() != 0) fail_timeout("drain");
        rdy_mode = 0;
        repeat (4) @(posedge CLK);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
